uart_tx_ctrl: RTL and testbench

- Byte-stream front end sitting directly upstream of the UART serializer in the ESP Wi-Fi link.
- Buffers bytes from the command/payload generator in a synchronous FIFO.
- Issues one `tx_req` pulse per byte, with the byte on `tx_din`, only when the serializer reports idle.
- Tracks the serializer's idle→busy→idle cycle so bytes are never overwritten mid-frame.

---
 rtl/uart_tx_ctrl_pkg.sv | 34 +++
 rtl/uart_tx_ctrl_if.sv | 28 ++
 rtl/uart_tx_ctrl_sync_fifo.sv | 57 +++++
 rtl/uart_tx_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// rtl/uart_tx_ctrl_pkg.sv - shared types and constants for the UART TX front end
// Contents: system clock / baud constants, default FIFO geometry,
// FSM state encoding, CR/LF terminator bytes (used when TX_CRLF_EN is defined).
package uart_tx_ctrl_pkg;

    localparam int SYS_FRQ  = 50_000_000;
    localparam int BAUD_MAX = 115_200;

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

    localparam logic [7:0] CR_BYTE = 8'h0D;
    localparam logic [7:0] LF_BYTE = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_CR        = 3'd4,
        ST_LF        = 3'd5
    } state_t;

    // Serializer clock divider for the fastest supported baud rate.
    function automatic int baud_div();
        return SYS_FRQ / BAUD_MAX;
    endfunction

    // Terminator byte for the given step: 0 -> CR, 1 -> LF.
    function automatic logic [7:0] term_byte(input logic second);
        return second ? LF_BYTE : CR_BYTE;
    endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// rtl/uart_tx_ctrl_if.sv - producer and serializer handshake bundle
// Signals: wr_en/wr_data/wr_last (producer write), full/empty/ovf/busy (status),
// tx_req/tx_din (to serializer), tx_idle (from serializer).
// slave: the controller side; master: the producer/serializer side.
interface uart_tx_ctrl_if;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       tx_req;
    logic [7:0] tx_din;
    logic       tx_idle;

    modport master (
        output wr_en, wr_data, wr_last, tx_idle,
        input  full, empty, ovf, busy, tx_req, tx_din
    );

    modport slave (
        input  wr_en, wr_data, wr_last, tx_idle,
        output full, empty, ovf, busy, tx_req, tx_din
    );

endinterface

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// rtl/uart_tx_ctrl_sync_fifo.sv - synchronous FIFO with registered full/empty
// Ports: clk, rst_n (sync active-low), wr_en/wr_data (write, ignored when full),
// rd_en (pop, ignored when empty), dout (current head), full, empty.
// Pointers carry one extra wrap bit; reset clears pointers only, not storage.
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr, rd_ptr;
    logic [ADDR_W:0]  wr_ptr_d, rd_ptr_d;
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr + {{ADDR_W{1'b0}}, do_wr};
        rd_ptr_d = rd_ptr + {{ADDR_W{1'b0}}, do_rd};
    end

    // Flags are computed from the next pointers so they land on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            full   <= (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]) &&
                      (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]);
            empty  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign dout = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - byte FIFO and request FSM in front of the UART serializer
// Ports: clk, rst_n (sync active-low), bus (uart_tx_ctrl_if.slave):
//   wr_en/wr_data/wr_last in, full/empty/ovf/busy out,
//   tx_req/tx_din out to serializer, tx_idle in from serializer.
// Optional: TX_CRLF_EN appends 0x0D 0x0A after a byte written with wr_last.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_ctrl_if.slave bus
);

`ifdef TX_CRLF_EN
    localparam int FIFO_W = 9;
    logic [FIFO_W-1:0] fifo_wdata;
    assign fifo_wdata = {bus.wr_last, bus.wr_data};
`else
    localparam int FIFO_W = 8;
    logic [FIFO_W-1:0] fifo_wdata;
    logic              unused_wr_last;
    assign fifo_wdata     = bus.wr_data;
    assign unused_wr_last = bus.wr_last;
`endif

    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;

    state_t     state_q, state_d;
    logic [7:0] tx_din_q, tx_din_d;
    logic       ovf_q;
`ifdef TX_CRLF_EN
    // 2: CR then LF still to send, 1: LF still to send, 0: nothing pending.
    logic [1:0] term_q, term_d;
`endif

    sync_fifo #(
        .WIDTH  (FIFO_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        tx_din_d = tx_din_q;
        pop      = 1'b0;
`ifdef TX_CRLF_EN
        term_d   = term_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && bus.tx_idle) begin
                    pop      = 1'b1;
                    tx_din_d = fifo_dout[7:0];
                    state_d  = ST_REQ;
`ifdef TX_CRLF_EN
                    term_d   = fifo_dout[8] ? 2'd2 : 2'd0;
`endif
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.tx_idle) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_idle) begin
`ifdef TX_CRLF_EN
                    if (term_q == 2'd2) begin
                        state_d = ST_CR;
                    end else if (term_q == 2'd1) begin
                        state_d = ST_LF;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef TX_CRLF_EN
            // Terminator bytes reuse the normal request path; the idle
            // check keeps tx_req from ever firing into a busy serializer.
            ST_CR: begin
                if (bus.tx_idle) begin
                    tx_din_d = term_byte(1'b0);
                    term_d   = 2'd1;
                    state_d  = ST_REQ;
                end
            end
            ST_LF: begin
                if (bus.tx_idle) begin
                    tx_din_d = term_byte(1'b1);
                    term_d   = 2'd0;
                    state_d  = ST_REQ;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tx_din_q <= 8'h00;
            ovf_q    <= 1'b0;
`ifdef TX_CRLF_EN
            term_q   <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            tx_din_q <= tx_din_d;
            // Uses the registered full, so a same-cycle pop does not rescue the write.
            ovf_q    <= bus.wr_en && fifo_full;
`ifdef TX_CRLF_EN
            term_q   <= term_d;
`endif
        end
    end

    assign bus.full   = fifo_full;
    assign bus.empty  = fifo_empty;
    assign bus.ovf    = ovf_q;
    assign bus.busy   = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.tx_req = (state_q == ST_REQ);
    assign bus.tx_din = tx_din_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_ctrl_if bus();

    uart_tx_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Serializer model: idle drops the cycle after tx_req, stays low frame_len cycles.
    logic       model_idle = 1'b1;
    logic       hold_low   = 1'b0;
    int         frame_len  = 3;
    int         busy_cnt   = 0;
    int         bad_req    = 0;
    logic [7:0] sent[$];

    assign bus.tx_idle = model_idle && !hold_low;

    always @(posedge clk) begin
        if (bus.tx_req === 1'b1) begin
            sent.push_back(bus.tx_din);
            if (bus.tx_idle !== 1'b1) bad_req++;
            model_idle <= 1'b0;
            busy_cnt   <= frame_len;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt   <= 0;
            model_idle <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d, input logic last);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        bus.wr_last = last;
        tick();
        bus.wr_en   = 1'b0;
        bus.wr_last = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (bus.busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_full"},   {31'd0, bus.full},   32'd0);
        check({tag, "_empty"},  {31'd0, bus.empty},  32'd1);
        check({tag, "_ovf"},    {31'd0, bus.ovf},    32'd0);
        check({tag, "_busy"},   {31'd0, bus.busy},   32'd0);
        check({tag, "_tx_req"}, {31'd0, bus.tx_req}, 32'd0);
        check({tag, "_tx_din"}, {24'd0, bus.tx_din}, 32'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_seq[$];
        int         bb_seen;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.wr_last = 1'b0;

        // Reset values
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_values("rst");
        rst_n = 1'b1;

        // Single byte latency: write in cycle N -> tx_req in cycle N+2
        frame_len = 100;
        wr(8'h55, 1'b0);
        check("lat_n1_req", {31'd0, bus.tx_req}, 32'd0);
        tick();
        check("lat_n2_req", {31'd0, bus.tx_req}, 32'd1);
        check("lat_n2_din", {24'd0, bus.tx_din}, 32'h55);
        tick();
        check("lat_n3_req", {31'd0, bus.tx_req}, 32'd0);
        wait_idle(300);
        check("single_count", sent.size(), 32'd1);
        check("single_byte", {24'd0, sent[0]}, 32'h55);
        check("single_idle", {31'd0, bus.tx_idle}, 32'd1);

        // Fill with serializer held busy, then overflow with 0xAA
        hold_low  = 1'b1;
        frame_len = 3;
        sent.delete();
        for (int i = 1; i <= 16; i++) wr(8'(i), 1'b0);
        check("fill_full", {31'd0, bus.full}, 32'd1);
        check("fill_empty", {31'd0, bus.empty}, 32'd0);
        check("fill_ovf0", {31'd0, bus.ovf}, 32'd0);
        wr(8'hAA, 1'b0);
        check("ovf_pulse", {31'd0, bus.ovf}, 32'd1);
        tick();
        check("ovf_clear", {31'd0, bus.ovf}, 32'd0);
        check("ovf_full", {31'd0, bus.full}, 32'd1);
        check("held_no_req", sent.size(), 32'd0);

        // Drain all 16 in order
        hold_low = 1'b0;
        wait_idle(1000);
        check("drain_count", sent.size(), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("drain_byte%0d", i), {24'd0, sent[i]}, 32'(i + 1));
        check("drain_bad_req", bad_req, 32'd0);
        check("drain_empty", {31'd0, bus.empty}, 32'd1);

        // Write while full in the same cycle as a pop
        hold_low = 1'b1;
        sent.delete();
        for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1'b0);
        check("pop_full_pre", {31'd0, bus.full}, 32'd1);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hBB;
        hold_low    = 1'b0;
        tick();
        bus.wr_en   = 1'b0;
        check("pop_full_ovf", {31'd0, bus.ovf}, 32'd1);
        check("pop_full_full", {31'd0, bus.full}, 32'd0);
        check("pop_full_empty", {31'd0, bus.empty}, 32'd0);
        wait_idle(1000);
        check("pop_full_count", sent.size(), 32'd16);
        check("pop_full_first", {24'd0, sent[0]}, 32'h20);
        check("pop_full_last", {24'd0, sent[15]}, 32'h2F);
        bb_seen = 0;
        foreach (sent[i]) if (sent[i] == 8'hBB) bb_seen++;
        check("pop_full_no_bb", bb_seen, 32'd0);

        // Reset while WAIT_DONE with 5 bytes still queued
        hold_low  = 1'b1;
        frame_len = 50;
        sent.delete();
        for (int i = 0; i < 6; i++) wr(8'h60 + 8'(i), 1'b0);
        hold_low = 1'b0;
        repeat (8) tick();
        check("mid_tx_idle", {31'd0, bus.tx_idle}, 32'd0);
        check("mid_sent", sent.size(), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("midrst");
        sent.delete();
        repeat (150) tick();
        check("midrst_no_req", sent.size(), 32'd0);
        check("midrst_empty", {31'd0, bus.empty}, 32'd1);

        // "AT" with wr_last on 'T'
        frame_len = 3;
        sent.delete();
        wr(8'h41, 1'b0);
        wr(8'h54, 1'b1);
        wait_idle(500);
        repeat (5) tick();
`ifdef TX_CRLF_EN
        exp_seq = '{8'h41, 8'h54, 8'h0D, 8'h0A};
`else
        exp_seq = '{8'h41, 8'h54};
`endif
        check("at_count", sent.size(), exp_seq.size());
        foreach (exp_seq[i])
            check($sformatf("at_byte%0d", i), {24'd0, sent[i]}, {24'd0, exp_seq[i]});
        check("final_bad_req", bad_req, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
